// File: rtl/alu_sequencer.sv
// Drives an external combinational ALU from a valid/ready command stream.
// A load responds in 1 cycle and an op in N passes; cmd_ready is low from acceptance until the response handshake.
module alu_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_operand,
    input  logic [CNT_W-1:0] cmd_count,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_borrow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_borrow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rcarry_q, rcarry_d;
    logic             rborrow_q, rborrow_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            opnd_q    <= '0;
            op_q      <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            rcarry_q  <= 1'b0;
            rborrow_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            rcarry_q  <= rcarry_d;
            rborrow_q <= rborrow_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        rcarry_d  = rcarry_q;
        rborrow_d = rborrow_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_load) begin
                        acc_d     = cmd_operand;
                        rdata_d   = cmd_operand;
                        rcarry_d  = 1'b0;
                        rborrow_d = 1'b0;
                        state_d   = RESP;
                    end else begin
                        op_d    = cmd_op;
                        opnd_d  = cmd_operand;
                        // Only the shift ops repeat; a zero count still means one pass.
                        if (cmd_op[2:1] == 2'b11 && cmd_count != '0) begin
                            cnt_d = cmd_count;
                        end else begin
                            cnt_d = CNT_W'(1);
                        end
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                acc_d     = alu_result;
                rcarry_d  = alu_carry;
                rborrow_d = alu_borrow;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    rdata_d = alu_result;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign alu_x      = acc_q;
    assign alu_y      = opnd_q;
    assign alu_sel    = op_q;
    assign rsp_data   = rdata_q;
    assign rsp_carry  = rcarry_q;
    assign rsp_borrow = rborrow_q;

endmodule
